// File: rtl/saes_pkg.sv
// Shared S-AES types, MixColumns coefficients, stage FSM encoding and GF(2^4) multiply.
// Used by the MixColumns stage and intended for the key-expansion and SubNibbles blocks.
package saes_pkg;

    typedef logic [15:0] state_t;
    typedef logic [3:0]  nibble_t;

    localparam nibble_t MC_FWD_A = 4'h1;
    localparam nibble_t MC_FWD_B = 4'h4;
    localparam nibble_t MC_INV_A = 4'h9;
    localparam nibble_t MC_INV_B = 4'h2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COL0 = 2'd1,
        COL1 = 2'd2,
        OUT  = 2'd3
    } mc_fsm_t;

    // Shift-and-add: the running multiplicand is reduced every step, so the
    // product never grows past 4 bits.
    function automatic nibble_t gf4_mul(input nibble_t a, input nibble_t b, input nibble_t poly);
        nibble_t acc;
        nibble_t x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                acc = acc ^ x;
            end
            x = {x[2:0], 1'b0} ^ (x[3] ? poly : 4'h0);
        end
        return acc;
    endfunction

endpackage

// File: rtl/mix_column_unit.sv
// One S-AES MixColumns column: 2 nibbles in, 2 nibbles out, forward or inverse matrix.
// Purely combinational; time-shared across both columns by the sequential stage.
module mix_column_unit
    import saes_pkg::*;
#(
    parameter nibble_t POLY = 4'b0011
) (
    input  nibble_t i_s0,
    input  nibble_t i_s1,
    input  logic    i_mode,
    output nibble_t o_s0,
    output nibble_t o_s1
);

    nibble_t w_a;
    nibble_t w_b;

    // Both matrices have the form [[A,B],[B,A]], so only the coefficients change.
    assign w_a = i_mode ? MC_INV_A : MC_FWD_A;
    assign w_b = i_mode ? MC_INV_B : MC_FWD_B;

    assign o_s0 = gf4_mul(i_s0, w_a, POLY) ^ gf4_mul(i_s1, w_b, POLY);
    assign o_s1 = gf4_mul(i_s0, w_b, POLY) ^ gf4_mul(i_s1, w_a, POLY);

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential S-AES MixColumns stage: one column per cycle, result valid 3 cycles after accept (1 with bypass).
// Single-block, no overlap: in_ready only in IDLE; result is held stable in OUT until out_ready.
module mix_columns_seq
    import saes_pkg::*;
#(
    parameter nibble_t POLY = 4'b0011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] data_in,
    input  logic        mode,
    input  logic        bypass,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] data_out
);

    mc_fsm_t r_state;
    mc_fsm_t w_next;

    state_t      r_data;
    logic        r_mode;
    logic [7:0]  r_hi;
    state_t      r_dout;

    nibble_t w_col_s0;
    nibble_t w_col_s1;
    nibble_t w_mc_s0;
    nibble_t w_mc_s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = bypass ? OUT : COL0;
                end
            end
            COL0: w_next = COL1;
            COL1: w_next = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
        endcase
    end

    assign w_col_s0 = (r_state == COL0) ? r_data[15:12] : r_data[7:4];
    assign w_col_s1 = (r_state == COL0) ? r_data[11:8]  : r_data[3:0];

    mix_column_unit #(
        .POLY (POLY)
    ) u_mcu (
        .i_s0   (w_col_s0),
        .i_s1   (w_col_s1),
        .i_mode (r_mode),
        .o_s0   (w_mc_s0),
        .o_s1   (w_mc_s1)
    );

    // data_out only changes when a complete result is written, so it never
    // shows a half-built state and holds after the block leaves OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_mode <= 1'b0;
            r_hi   <= '0;
            r_dout <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data <= data_in;
                        r_mode <= mode;
                        if (bypass) begin
                            r_dout <= data_in;
                        end
                    end
                end
                COL0: r_hi   <= {w_mc_s0, w_mc_s1};
                COL1: r_dout <= {r_hi, w_mc_s0, w_mc_s1};
                OUT: ;
            endcase
        end
    end

    assign data_out = r_dout;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed and random checks of the S-AES MixColumns stage against an independent GF(2^4) model.
module tb_mix_columns_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data_in;
    logic        mode;
    logic        bypass;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] data_out;

    int          n_cmp;
    int          n_fail;
    logic [15:0] exp_q[$];

    mix_columns_seq #(.POLY(4'b0011)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .mode      (mode),
        .bypass    (bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    // Full carry-less product first, then fold x^6..x^4 with x^4+x+1.
    function automatic logic [3:0] m_mul(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ ({3'b000, a} << i);
        end
        for (int k = 6; k >= 4; k--) begin
            if (p[k]) p = p ^ (7'b0010011 << (k - 4));
        end
        return p[3:0];
    endfunction

    function automatic logic [15:0] m_mc(input logic [15:0] s, input logic inv);
        logic [3:0] ca;
        logic [3:0] cb;
        logic [15:0] r;
        ca = inv ? 4'h9 : 4'h1;
        cb = inv ? 4'h2 : 4'h4;
        r[15:12] = m_mul(ca, s[15:12]) ^ m_mul(cb, s[11:8]);
        r[11:8]  = m_mul(cb, s[15:12]) ^ m_mul(ca, s[11:8]);
        r[7:4]   = m_mul(ca, s[7:4])   ^ m_mul(cb, s[3:0]);
        r[3:0]   = m_mul(cb, s[7:4])   ^ m_mul(ca, s[3:0]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One transaction; hold>0 keeps out_ready low for that many cycles in OUT
    // while a competing in_valid pulse is driven.
    task automatic run(input logic [15:0] d, input logic m, input logic b,
                       input int hold, input string tag, output logic [15:0] res);
        int n;
        logic [15:0] held;
        logic [15:0] expv;
        out_ready = (hold == 0);
        @(negedge clk);
        chk({tag, "/in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        data_in  = d;
        mode     = m;
        bypass   = b;
        exp_q.push_back(b ? d : m_mc(d, m));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_in  = 'x;
        mode     = ~m;
        bypass   = ~b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk({tag, "/latency"}, 32'(n), b ? 32'd1 : 32'd3);
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        chk({tag, "/data_out"}, 32'(data_out), 32'(expv));
        res  = data_out;
        held = data_out;
        if (hold > 0) begin
            in_valid = 1'b1;
            data_in  = 16'hFFFF;
            mode     = 1'b0;
            bypass   = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
                chk({tag, "/hold_data"}, 32'(data_out), 32'(held));
                chk({tag, "/hold_in_ready"}, 32'(in_ready), 32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk({tag, "/valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "/in_ready_back"}, 32'(in_ready), 32'd1);
        chk({tag, "/data_after"}, 32'(data_out), 32'(held));
        if (hold > 0) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk({tag, "/no_second_accept"}, 32'(out_valid), 32'd0);
            end
        end
    endtask

    initial begin
        logic [15:0] r;
        logic [15:0] fw;
        logic [15:0] st;
        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        data_in   = 16'h0000;
        mode      = 1'b0;
        bypass    = 1'b0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset/in_ready", 32'(in_ready), 32'd1);
        chk("reset/out_valid", 32'(out_valid), 32'd0);
        chk("reset/data_out", 32'(data_out), 32'h0000);
        rst = 1'b0;

        run(16'h6C07, 1'b0, 1'b0, 0, "fwd_6C07", r);
        chk("fwd_6C07/const", 32'(r), 32'h37F7);
        run(16'h1000, 1'b0, 1'b0, 0, "fwd_1000", r);
        chk("fwd_1000/const", 32'(r), 32'h1400);
        run(16'h0100, 1'b0, 1'b0, 0, "fwd_0100", r);
        chk("fwd_0100/const", 32'(r), 32'h4100);
        run(16'h1400, 1'b1, 1'b0, 0, "inv_1400", r);
        chk("inv_1400/const", 32'(r), 32'h1000);
        run(16'hA5C3, 1'b0, 1'b1, 0, "bypass", r);
        chk("bypass/const", 32'(r), 32'hA5C3);

        run(16'hBEEF, 1'b0, 1'b0, 5, "backpressure", r);

        // Abort in COL1: previous result must be wiped and never replaced.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        data_in   = 16'h1234;
        mode      = 1'b0;
        bypass    = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid/out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid/in_ready", 32'(in_ready), 32'd1);
        chk("rst_mid/data_out", 32'(data_out), 32'h0000);
        rst = 1'b0;
        run(16'h6C07, 1'b0, 1'b0, 0, "after_rst", r);
        chk("after_rst/const", 32'(r), 32'h37F7);

        for (int i = 0; i < 256; i++) begin
            st = 16'($urandom);
            run(st, 1'b0, 1'b0, 0, "rand_fwd", fw);
            run(fw, 1'b1, 1'b0, 0, "rand_inv", r);
            chk("rand_roundtrip", 32'(r), 32'(st));
        end

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
